// File: rtl/snn_seq_pkg.sv
// Shared FSM state type and default sizing for the SNN timestep sequencer.
package snn_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      SETTLE_ST,
      CAPTURE
   } seq_state_t;

   localparam int DEF_N_IN       = 8;
   localparam int DEF_N_OUT      = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_DIV_W      = 8;
   localparam int DEF_TS_W       = 16;
   localparam int DEF_SETTLE     = 2;

endpackage

// File: rtl/snn_timestep_sequencer_if.sv
// Spike-frame input stream and captured-result output stream of the timestep sequencer.
interface snn_timestep_sequencer_if
   import snn_seq_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int N_OUT = DEF_N_OUT,
   parameter int TS_W  = DEF_TS_W
);
   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_spikes;
   logic              out_valid;
   logic              out_ready;
   logic [N_OUT-1:0]  out_spikes;
   logic [TS_W-1:0]   out_timestep;

   modport master (
      output in_valid, in_spikes, out_ready,
      input  in_ready, out_valid, out_spikes, out_timestep
   );

   modport slave (
      input  in_valid, in_spikes, out_ready,
      output in_ready, out_valid, out_spikes, out_timestep
   );
endinterface

// File: rtl/snn_spike_fifo.sv
// Spike-frame FIFO; pushes while full are dropped, head is read straight from the storage flops.
module snn_spike_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra MSB on each pointer separates full from empty when the indices match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/snn_timestep_sequencer.sv
// Sequences one SNN timestep per buffered spike frame and captures the core's output spikes.
// SNN_SEQ_FREE_RUN_EN: keep running timesteps with an all-zero frame while the FIFO is empty.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for cfg_valid and a frame
// LOAD      | pop frame to snn_input_spikes, latch div_value into cnt
// RUN       | core enabled, cnt counts down, delay_tick on cnt==0
// SETTLE_ST | core enabled, scnt counts down before output sampling
// CAPTURE   | sample output spikes into result stage, stall while it is full
module snn_timestep_sequencer
   import snn_seq_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int N_OUT      = DEF_N_OUT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DIV_W      = DEF_DIV_W,
   parameter int TS_W       = DEF_TS_W,
   parameter int SETTLE     = DEF_SETTLE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   input  logic [DIV_W-1:0]     div_value,
   snn_timestep_sequencer_if.slave bus,
   output logic                 snn_enable,
   output logic [N_IN-1:0]      snn_input_spikes,
   output logic                 delay_tick,
   input  logic [N_OUT-1:0]     snn_output_spikes,
   output logic                 busy,
   output logic                 drop_flag
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [DIV_W-1:0]  cnt;
   logic [SW-1:0]     scnt;
   logic [TS_W-1:0]   ts;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [N_IN-1:0]   fifo_head;
   logic              start_ok;
   logic              cap_fire;
   logic              out_valid_q;
   logic [N_OUT-1:0]  out_spikes_q;
   logic [TS_W-1:0]   out_ts_q;

   assign bus.in_ready     = !fifo_full;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_spikes   = out_spikes_q;
   assign bus.out_timestep = out_ts_q;
   assign busy             = (state != IDLE);

   snn_spike_fifo #(
      .WIDTH (N_IN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.in_valid),
      .pop   (fifo_pop),
      .wdata (bus.in_spikes),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef SNN_SEQ_FREE_RUN_EN
   assign start_ok = cfg_valid;
`else
   assign start_ok = cfg_valid && !fifo_empty;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      snn_enable = 1'b0;
      delay_tick = 1'b0;
      fifo_pop   = 1'b0;
      cap_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = LOAD;
         end
         LOAD: begin
            fifo_pop  = !fifo_empty;
            state_nxt = RUN;
         end
         RUN: begin
            snn_enable = 1'b1;
            if (cnt == '0) begin
               delay_tick = 1'b1;
               state_nxt  = SETTLE_ST;
            end
         end
         SETTLE_ST: begin
            snn_enable = 1'b1;
            if (scnt == '0) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (!out_valid_q || bus.out_ready) begin
               cap_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An empty FIFO in LOAD only happens in free-run mode; the core then sees a blank frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt              <= '0;
         scnt             <= '0;
         snn_input_spikes <= '0;
      end else begin
         case (state)
            LOAD: begin
               cnt              <= div_value;
               snn_input_spikes <= fifo_empty ? '0 : fifo_head;
            end
            RUN: begin
               cnt <= cnt - DIV_W'(1);
               if (cnt == '0) scnt <= SW'(SETTLE - 1);
            end
            SETTLE_ST: scnt <= scnt - SW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_spikes_q <= '0;
         out_ts_q     <= '0;
         ts           <= '0;
         drop_flag    <= 1'b0;
      end else begin
         if (cap_fire) begin
            out_valid_q  <= 1'b1;
            out_spikes_q <= snn_output_spikes;
            out_ts_q     <= ts;
            ts           <= ts + TS_W'(1);
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (bus.in_valid && fifo_full) drop_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// Bench for snn_timestep_sequencer: timeline model checked every cycle plus directed literal checks.
module tb_snn_timestep_sequencer;
   localparam int N_IN   = 8;
   localparam int N_OUT  = 8;
   localparam int DEPTH  = 4;
   localparam int DIV_W  = 8;
   localparam int TS_W   = 16;
   localparam int SETTLE = 2;
`ifdef SNN_SEQ_FREE_RUN_EN
   localparam bit FREE_RUN = 1'b1;
`else
   localparam bit FREE_RUN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_valid = 1'b0;
   logic [DIV_W-1:0] div_value = '0;
   logic             snn_enable;
   logic             delay_tick;
   logic             busy;
   logic             drop_flag;
   logic [N_IN-1:0]  snn_input_spikes;
   logic [N_OUT-1:0] snn_output_spikes;

   snn_timestep_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .TS_W(TS_W)) bus ();

   snn_timestep_sequencer #(
      .N_IN(N_IN), .N_OUT(N_OUT), .FIFO_DEPTH(DEPTH),
      .DIV_W(DIV_W), .TS_W(TS_W), .SETTLE(SETTLE)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .cfg_valid         (cfg_valid),
      .div_value         (div_value),
      .bus               (bus.slave),
      .snn_enable        (snn_enable),
      .snn_input_spikes  (snn_input_spikes),
      .delay_tick        (delay_tick),
      .snn_output_spikes (snn_output_spikes),
      .busy              (busy),
      .drop_flag         (drop_flag)
   );

   always #5 clk = ~clk;

   // Stand-in core: nibble swap of the held frame, inverted while enabled so a mistimed
   // capture (during RUN/SETTLE) is visible.
   function automatic logic [7:0] core_fn(input logic [7:0] f);
      return {f[3:0], f[7:4]};
   endfunction
   assign snn_output_spikes = core_fn(snn_input_spikes) ^ {N_OUT{snn_enable}};

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int en_cnt = 0;
   int tick_cnt = 0;
   int last_tick = 0;
   int tick_gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: a timestep is counted by its offset from the LOAD cycle.
   logic [7:0]  mq[$];
   bit          m_act;
   int          m_off;
   int          m_div;
   logic [7:0]  m_in;
   bit          m_ov;
   logic [7:0]  m_os;
   logic [15:0] m_ots;
   logic [15:0] m_ts;
   bit          m_drop;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      bit acc, start, fire;
      if (reset) begin
         mq.delete();
         m_act = 0; m_off = 0; m_div = 0; m_in = '0;
         m_ov = 0; m_os = '0; m_ots = '0; m_ts = '0; m_drop = 0;
      end
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_act));
      chk("snn_enable", 32'(snn_enable), 32'(m_act && m_off >= 1 && m_off <= m_div + 1 + SETTLE));
      chk("delay_tick", 32'(delay_tick), 32'(m_act && m_off == m_div + 1));
      chk("snn_input_spikes", 32'(snn_input_spikes), 32'(m_in));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("out_spikes", 32'(bus.out_spikes), 32'(m_os));
      chk("out_timestep", 32'(bus.out_timestep), 32'(m_ots));
      chk("drop_flag", 32'(drop_flag), 32'(m_drop));
      en_cnt += int'(snn_enable);
      if (delay_tick === 1'b1) begin
         tick_cnt++;
         tick_gap  = cyc - last_tick;
         last_tick = cyc;
      end
      if (!reset) begin
         acc   = bus.in_valid && (mq.size() < DEPTH);
         start = !m_act && cfg_valid && (mq.size() > 0 || FREE_RUN);
         fire  = m_act && m_off >= m_div + 2 + SETTLE && (!m_ov || bus.out_ready);
         if (bus.in_valid && !acc) m_drop = 1;
         if (m_act && m_off == 0) begin
            m_div = int'(div_value);
            if (mq.size() > 0) m_in = mq.pop_front();
            else               m_in = '0;
         end
         if (acc) mq.push_back(bus.in_spikes);
         if (fire) begin
            m_os  = core_fn(m_in);
            m_ots = m_ts;
            m_ts  = m_ts + 16'd1;
            m_ov  = 1;
            m_act = 0;
         end else begin
            if (bus.out_ready) m_ov = 0;
            if (m_act) m_off++;
         end
         if (start) begin
            m_act = 1;
            m_off = 0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_spikes = '0;
      bus.out_ready = 1'b0;
      cfg_valid     = 1'b0;
      reset         = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic push_frames(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                              input logic [7:0] f3, input logic [7:0] f4, input int n);
      logic [7:0] fr [5];
      fr[0] = f0; fr[1] = f1; fr[2] = f2; fr[3] = f3; fr[4] = f4;
      for (int i = 0; i < n; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_spikes = fr[i];
         step(1);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out_valid(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         step(1);
         if (bus.out_valid === 1'b1) ok = 1;
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_out_valid: no result within %0d cycles", lim);
      end
   endtask

   initial begin
      bit ok;
      int p, e0, t0, nres;
      logic [15:0] rts [8];
      logic [7:0]  rsp [8];
      logic [7:0]  exp2 [4];

      bus.in_valid  = 1'b0;
      bus.in_spikes = '0;
      bus.out_ready = 1'b0;

      // 1: single frame, div_value=3
      do_reset();
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      cfg_valid = 1'b1;
      div_value = 8'd3;
      e0 = en_cnt; t0 = tick_cnt;
      push_frames(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      p = cyc;
      wait_out_valid(30, ok);
      chk("t1_latency", 32'(cyc - p), 32'd9);
      chk("t1_input", 32'(snn_input_spikes), 32'hA5);
      chk("t1_enable_cycles", 32'(en_cnt - e0), 32'(4 + SETTLE));
      chk("t1_ticks", 32'(tick_cnt - t0), 32'd1);
      chk("t1_out_spikes", 32'(bus.out_spikes), 32'h5A);
      chk("t1_out_ts", 32'(bus.out_timestep), 32'd0);

      // 2: five back-to-back frames into a depth-4 FIFO
      do_reset();
      bus.out_ready = 1'b1;
      div_value = 8'd1;
      push_frames(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 5);
      chk("t2_drop_flag", 32'(drop_flag), 32'd1);
      chk("t2_full", 32'(bus.in_ready), 32'd0);
      cfg_valid = 1'b1;
      nres = 0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (bus.out_valid === 1'b1 && nres < 8) begin
            rts[nres] = bus.out_timestep;
            rsp[nres] = bus.out_spikes;
            nres++;
         end
      end
      chk("t2_results", 32'(nres), 32'd4);
      exp2[0] = 8'h21; exp2[1] = 8'h43; exp2[2] = 8'h65; exp2[3] = 8'h87;
      for (int i = 0; i < 4 && i < nres; i++) begin
         chk("t2_ts", 32'(rts[i]), 32'(i));
         chk("t2_spikes", 32'(rsp[i]), 32'(exp2[i]));
      end

      // 3: result stage full stalls the second timestep in CAPTURE
      do_reset();
      cfg_valid = 1'b1;
      div_value = 8'd2;
      push_frames(8'hC3, 8'h0F, 8'h00, 8'h00, 8'h00, 2);
      wait_out_valid(30, ok);
      step(12);
      chk("t3_stall_busy", 32'(busy), 32'd1);
      chk("t3_stall_enable", 32'(snn_enable), 32'd0);
      chk("t3_stall_ts", 32'(bus.out_timestep), 32'd0);
      chk("t3_stall_spikes", 32'(bus.out_spikes), 32'h3C);
      bus.out_ready = 1'b1;
      step(1);
      chk("t3_release_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_release_ts", 32'(bus.out_timestep), 32'd1);
      chk("t3_release_spikes", 32'(bus.out_spikes), 32'hF0);
      chk("t3_release_busy", 32'(busy), 32'd0);
      step(1);
      chk("t3_drained", 32'(bus.out_valid), 32'd0);

      // 4: div_value=0, tick spacing
      do_reset();
      cfg_valid = 1'b1;
      bus.out_ready = 1'b1;
      div_value = 8'd0;
      e0 = en_cnt; t0 = tick_cnt;
      push_frames(8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 4);
      step(60);
      chk("t4_ticks", 32'(tick_cnt - t0), 32'd4);
      chk("t4_tick_gap", 32'(tick_gap), 32'(4 + SETTLE));
      chk("t4_enable_cycles", 32'(en_cnt - e0), 32'(4 * (1 + SETTLE)));

      // 5: reset during RUN
      do_reset();
      cfg_valid = 1'b1;
      div_value = 8'd5;
      push_frames(8'h3C, 8'h81, 8'h00, 8'h00, 8'h00, 2);
      step(2);
      chk("t5_in_run", 32'(snn_enable), 32'd1);
      chk("t5_frame", 32'(snn_input_spikes), 32'h3C);
      reset = 1'b1;
      #1;
      chk("t5_rst_enable", 32'(snn_enable), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t5_rst_frame", 32'(snn_input_spikes), 32'd0);
      step(1);
      reset = 1'b0;
      step(10);
      chk("t5_after_frame", 32'(snn_input_spikes), 32'd0);
`ifndef SNN_SEQ_FREE_RUN_EN
      chk("t5_fifo_empty_idle", 32'(busy), 32'd0);
`endif

      // 6: cfg_valid with no frames
      do_reset();
      bus.out_ready = 1'b1;
      div_value = 8'd1;
      cfg_valid = 1'b1;
      t0 = tick_cnt;
      nres = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (bus.out_valid === 1'b1 && nres < 8) begin
            rts[nres] = bus.out_timestep;
            rsp[nres] = bus.out_spikes;
            nres++;
         end
      end
`ifdef SNN_SEQ_FREE_RUN_EN
      chk("t6_free_results", 32'(nres >= 3), 32'd1);
      for (int i = 0; i < 3 && i < nres; i++) begin
         chk("t6_free_ts", 32'(rts[i]), 32'(i));
         chk("t6_free_spikes", 32'(rsp[i]), 32'd0);
      end
`else
      chk("t6_results", 32'(nres), 32'd0);
      chk("t6_ticks", 32'(tick_cnt - t0), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
